// File: rtl/async_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : async_fifo_pkg
//  Description : Shared pointer helpers for the dual-clock Gray-pointer FIFO.
//                Used by the read-side empty/level block and by the write-side
//                full/level block.
//  Revision    : 1.0 - initial release
// ============================================================================
package async_fifo_pkg;

    // Widest pointer the helpers handle. Callers zero-extend into this
    // container and truncate the result back to their own width.
    localparam int MAX_PTR_W = 32;

    // Pointer width for a given RAM address width. The extra MSB tells the
    // full case apart from the empty case.
    function automatic int ptr_w(input int addrsize);
        return addrsize + 1;
    endfunction

    // Binary to Gray. Zero-extension commutes with this conversion, so one
    // 32-bit implementation serves every pointer width.
    function automatic logic [MAX_PTR_W-1:0] bin2gray(input logic [MAX_PTR_W-1:0] ptr);
        return ptr ^ (ptr >> 1);
    endfunction

    // Gray to binary (XOR prefix from the MSB down). Also width-agnostic
    // under zero-extension.
    function automatic logic [MAX_PTR_W-1:0] gray2bin(input logic [MAX_PTR_W-1:0] ptr);
        logic [MAX_PTR_W-1:0] bin;
        bin[MAX_PTR_W-1] = ptr[MAX_PTR_W-1];
        for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ ptr[i];
        end
        return bin;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gray2bin_conv.sv
`default_nettype none
// ============================================================================
//  Module      : gray2bin_conv
//  Description : Combinational Gray-to-binary converter (XOR prefix).
//                Converts a synchronised Gray pointer into binary for level
//                arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
module gray2bin_conv #(
    parameter int W = 5
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    // Each binary bit is the XOR of all Gray bits at or above it.
    for (genvar i = 0; i < W; i++) begin : g_bit
        assign bin[i] = ^gray[W-1:i];
    end

endmodule
`default_nettype wire

// File: rtl/rptr_empty_level.sv
`default_nettype none
// ============================================================================
//  Module      : rptr_empty_level
//  Description : Read-domain pointer and flag controller for the dual-clock
//                Gray-pointer asynchronous FIFO. Produces the RAM read
//                address, the Gray read pointer for the write side, and the
//                empty / almost-empty / occupancy outputs. Reads on an empty
//                FIFO are ignored.
//  Config      : define RPTR_UNDERFLOW_EN to add the sticky underflow flag
//                rerr and its clear input rerr_clr.
//  Revision    : 1.0 - initial release
// ============================================================================
module rptr_empty_level
    import async_fifo_pkg::*;
#(
    parameter int ADDRSIZE = 4
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic                rinc,
    input  logic [ADDRSIZE:0]   wptr_q2,
    input  logic [ADDRSIZE:0]   rae_thresh,
    output logic [ADDRSIZE-1:0] read_addr,
    output logic [ADDRSIZE:0]   read_ptr,
    output logic                rempty,
    output logic                ralmost_empty,
    output logic [ADDRSIZE:0]   rlevel
`ifdef RPTR_UNDERFLOW_EN
    ,
    output logic                rerr,
    input  logic                rerr_clr
`endif
);

    localparam int PTR_W = ADDRSIZE + 1;

    // Occupancy of a completely full FIFO, at pointer width.
    localparam logic [PTR_W-1:0] DEPTH = {1'b1, {ADDRSIZE{1'b0}}};

    logic [PTR_W-1:0] rbin;
    logic [PTR_W-1:0] rbinnext;
    logic [PTR_W-1:0] rgraynext;
    logic [PTR_W-1:0] wbin_q2;
    logic [PTR_W-1:0] lvl_raw;
    logic [PTR_W-1:0] lvl_next;
    logic             rd_ok;

    // Write pointer back to binary so the level is a plain subtraction.
    gray2bin_conv #(
        .W (PTR_W)
    ) u_wptr_conv (
        .gray (wptr_q2),
        .bin  (wbin_q2)
    );

    // A read only advances the pointer when something is there to read.
    assign rd_ok     = rinc & ~rempty;
    assign rbinnext  = rbin + {{ADDRSIZE{1'b0}}, rd_ok};
    assign rgraynext = PTR_W'(bin2gray(MAX_PTR_W'(rbinnext)));
    assign lvl_raw   = wbin_q2 - rbinnext;

    // A corrupt synchronised pointer can produce a distance above DEPTH;
    // saturate so downstream logic never sees an impossible occupancy.
    always_comb begin
        lvl_next = lvl_raw;
        if (lvl_raw > DEPTH) begin
            lvl_next = DEPTH;
        end
    end

    assign read_addr = rbin[ADDRSIZE-1:0];

    // Pointer and flag registers, all derived from next-state values so the
    // flags line up with the pointer they describe.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin          <= '0;
            read_ptr      <= '0;
            rempty        <= 1'b1;
            ralmost_empty <= 1'b1;
            rlevel        <= '0;
        end else begin
            rbin          <= rbinnext;
            read_ptr      <= rgraynext;
            rempty        <= (rgraynext == wptr_q2);
            ralmost_empty <= (lvl_next <= rae_thresh);
            rlevel        <= lvl_next;
        end
    end

`ifdef RPTR_UNDERFLOW_EN
    logic underflow;
    assign underflow = rinc & rempty;

    // Sticky underflow flag; a new underflow takes priority over a clear.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rerr <= 1'b0;
        end else if (underflow) begin
            rerr <= 1'b1;
        end else if (rerr_clr) begin
            rerr <= 1'b0;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rptr_empty_level.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rptr_empty_level
//  Description : Self-checking bench for rptr_empty_level (ADDRSIZE=4).
//                The reference model counts total writes and reads as plain
//                integers; level, addresses and flags follow from those
//                counts.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rptr_empty_level;

    localparam int ADDRSIZE = 4;
    localparam int DEPTH    = 16;
    localparam int PMOD     = 32;

    logic       rclk = 1'b0;
    logic       rrst_n = 1'b1;
    logic       rinc = 1'b0;
    logic [4:0] wptr_q2 = '0;
    logic [4:0] rae_thresh = '0;
    logic [3:0] read_addr;
    logic [4:0] read_ptr;
    logic       rempty;
    logic       ralmost_empty;
    logic [4:0] rlevel;
`ifdef RPTR_UNDERFLOW_EN
    logic       rerr;
    logic       rerr_clr = 1'b0;
`endif

    rptr_empty_level #(
        .ADDRSIZE (ADDRSIZE)
    ) dut (
        .rclk          (rclk),
        .rrst_n        (rrst_n),
        .rinc          (rinc),
        .wptr_q2       (wptr_q2),
        .rae_thresh    (rae_thresh),
        .read_addr     (read_addr),
        .read_ptr      (read_ptr),
        .rempty        (rempty),
        .ralmost_empty (ralmost_empty),
        .rlevel        (rlevel)
`ifdef RPTR_UNDERFLOW_EN
        ,
        .rerr          (rerr),
        .rerr_clr      (rerr_clr)
`endif
    );

    always #5 rclk = ~rclk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: total entries written / read since the read pointer
    // was last reset, plus the empty state currently shown by the DUT.
    int w_total = 0;
    int r_total = 0;
    bit e_empty = 1'b1;
    bit e_rerr  = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int mod32(input int x);
        return ((x % PMOD) + PMOD) % PMOD;
    endfunction

    function automatic logic [4:0] gray5(input int b);
        logic [4:0] x;
        x = 5'(mod32(b));
        return x ^ (x >> 1);
    endfunction

    function automatic int exp_level();
        int m;
        m = mod32(w_total - r_total);
        return (m > DEPTH) ? DEPTH : m;
    endfunction

    task automatic check_outputs(input string tag);
        int lvl;
        lvl = exp_level();
        check_val({tag, ".rlevel"}, 32'(rlevel), 32'(lvl));
        check_val({tag, ".rempty"}, 32'(rempty), 32'(e_empty));
        check_val({tag, ".ralmost_empty"}, 32'(ralmost_empty), 32'(lvl <= int'(rae_thresh)));
        check_val({tag, ".read_addr"}, 32'(read_addr), 32'(r_total % DEPTH));
        check_val({tag, ".read_ptr"}, 32'(read_ptr), 32'(gray5(r_total)));
`ifdef RPTR_UNDERFLOW_EN
        check_val({tag, ".rerr"}, 32'(rerr), 32'(e_rerr));
`endif
    endtask

    // Apply current model write count, clock once, update model, check.
    task automatic step(input string tag);
        bit take;
        bit uf;
        wptr_q2 = gray5(w_total);
        take = rinc && !e_empty;
        uf   = rinc && e_empty;
        @(posedge rclk);
        if (take) r_total++;
`ifdef RPTR_UNDERFLOW_EN
        if (uf) e_rerr = 1'b1;
        else if (rerr_clr) e_rerr = 1'b0;
`else
        if (uf) e_rerr = 1'b0;
`endif
        #1;
        e_empty = (mod32(w_total - r_total) == 0);
        check_outputs(tag);
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, ".rempty"}, 32'(rempty), 32'd1);
        check_val({tag, ".ralmost_empty"}, 32'(ralmost_empty), 32'd1);
        check_val({tag, ".rlevel"}, 32'(rlevel), 32'd0);
        check_val({tag, ".read_ptr"}, 32'(read_ptr), 32'd0);
        check_val({tag, ".read_addr"}, 32'(read_addr), 32'd0);
`ifdef RPTR_UNDERFLOW_EN
        check_val({tag, ".rerr"}, 32'(rerr), 32'd0);
`endif
    endtask

    initial begin
        int guard;
        // Reset, checked while still asserted.
        #2 rrst_n = 1'b0;
        #1 check_reset_vals("rst");
        @(negedge rclk);
        @(negedge rclk);
        rrst_n = 1'b1;

        // Idle empty.
        rinc = 1'b0;
        step("idle");
        step("idle");

        // Three entries, threshold 1, drain.
        rae_thresh = 5'd1;
        w_total = 3;
        step("w3");
        rinc = 1'b1;
        repeat (3) step("rd3");
        rinc = 1'b0;
        step("rd3_done");

        // Full FIFO, then drain all sixteen.
        w_total = r_total + DEPTH;
        step("full");
        rinc = 1'b1;
        repeat (DEPTH) step("drain");
        rinc = 1'b0;
        step("drain_done");

        // Walk the read pointer to binary 30 one entry at a time.
        guard = 0;
        rinc = 1'b1;
        while (mod32(r_total) != 30 && guard < 200) begin
            if (w_total == r_total) w_total++;
            step("walk");
            guard++;
        end
        check_val("walk_reached", 32'(mod32(r_total)), 32'd30);
        rinc = 1'b0;
        step("walk_settle");

        // Wrap through 31 -> 0 -> 1.
        w_total = r_total + 3;
        step("wrap_fill");
        rinc = 1'b1;
        repeat (3) step("wrap_rd");
        rinc = 1'b0;
        step("wrap_done");

        // Underflow: reads on an empty FIFO must not move anything.
        rinc = 1'b1;
        repeat (4) step("uflow");
`ifdef RPTR_UNDERFLOW_EN
        rerr_clr = 1'b1;
        step("uflow_clr_collide");
        rinc = 1'b0;
        step("uflow_clr");
        rerr_clr = 1'b0;
`endif
        rinc = 1'b0;
        step("uflow_done");

        // Corrupt synchronised pointer: distance above DEPTH saturates.
        rae_thresh = 5'd15;
        w_total = r_total + 20;
        step("clamp");
        w_total = r_total;
        step("clamp_back");

        // Threshold boundaries.
        w_total = r_total + DEPTH;
        rae_thresh = 5'd16;
        step("thr16");
        rae_thresh = 5'd0;
        step("thr0_full");
        w_total = r_total;
        step("thr0_empty");

        // Randomised traffic.
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 7) == 0) rae_thresh = 5'($urandom_range(0, 31));
            if ((w_total - r_total) < DEPTH && $urandom_range(0, 1) == 1) w_total++;
            if ((w_total - r_total) < DEPTH && $urandom_range(0, 3) == 0) w_total++;
            rinc = 1'($urandom_range(0, 1));
`ifdef RPTR_UNDERFLOW_EN
            rerr_clr = ($urandom_range(0, 3) == 0);
`endif
            step("rand");
        end
        rinc = 1'b0;
`ifdef RPTR_UNDERFLOW_EN
        rerr_clr = 1'b0;
`endif

        // Reset mid-stream with five entries held.
        rae_thresh = 5'd2;
        w_total = r_total + 5;
        step("pre_rst");
        #3 rrst_n = 1'b0;
        #1 check_reset_vals("mid_rst");
        r_total = 0;
        e_empty = 1'b1;
        e_rerr  = 1'b0;
        @(negedge rclk);
        @(negedge rclk);
        rrst_n = 1'b1;
        step("post_rst");
        step("post_rst2");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
